// File: rtl/expand3_weight_sched_if.sv
// Handshake and control bundle between the expand3 weight sequencer and its
// surroundings: pass control, activation stream, ROM address, MAC strobes and output pixel.
interface expand3_weight_sched_if #(
    parameter int ADDR  = 7,
    parameter int PIX_W = 12
);
    logic             start;
    logic [PIX_W-1:0] num_pixels;
    logic             abort;
    logic             act_valid;
    logic             act_ready;
    logic [ADDR-1:0]  rom_addr;
    logic             mac_clr;
    logic             mac_en;
    logic             mac_last;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] pix_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start, num_pixels, abort, act_valid, out_ready,
        output act_ready, rom_addr, mac_clr, mac_en, mac_last,
               out_valid, pix_idx, busy, done
    );

    modport slave (
        output start, num_pixels, abort, act_valid, out_ready,
        input  act_ready, rom_addr, mac_clr, mac_en, mac_last,
               out_valid, pix_idx, busy, done
    );
endinterface

// File: rtl/expand3_weight_sched.sv
// Sequencer for the fire2 expand3 stage: walks the weight ROM once per output pixel,
// gates the 64 MAC lanes on the activation stream and hands finished pixels downstream.
module expand3_weight_sched #(
    parameter int ADDR    = 7,
    parameter int TAPS    = 128,
    parameter int PIX_W   = 12,
    parameter int MAC_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    expand3_weight_sched_if.master      bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [ADDR-1:0] LAST_TAP   = ADDR'(TAPS - 1);
    localparam logic [2:0]      DRAIN_LAST = 3'(MAC_LAT - 1);

    state_t           state_q, state_d;
    logic [ADDR-1:0]  rom_addr_q, rom_addr_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
    logic [PIX_W-1:0] num_q, num_d;
    logic [2:0]       drain_q, drain_d;
    logic             mac_clr_q, mac_clr_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        pix_idx_d  = pix_idx_q;
        num_d      = num_q;
        drain_d    = drain_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    num_d     = bus.num_pixels;
                    pix_idx_d = '0;
                    state_d   = (bus.num_pixels == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                rom_addr_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (bus.act_valid) begin
                    // The last tap is the only way out of RUN, so the address never passes TAPS-1.
                    if (rom_addr_q == LAST_TAP) begin
                        rom_addr_d = '0;
                        drain_d    = '0;
                        state_d    = (MAC_LAT == 0) ? S_OUT : S_DRAIN;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_OUT;
                end else begin
                    drain_d = drain_q + 3'(1);
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (pix_idx_q == num_q - PIX_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        pix_idx_d = pix_idx_q + PIX_W'(1);
                        state_d   = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d    = S_IDLE;
            rom_addr_d = '0;
            pix_idx_d  = '0;
            drain_d    = '0;
        end

        // Strobes are decoded from the next state so they are registered alongside it.
        mac_clr_d   = (state_d == S_CLEAR);
        out_valid_d = (state_d == S_OUT);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            pix_idx_q   <= '0;
            num_q       <= '0;
            drain_q     <= '0;
            mac_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            pix_idx_q   <= pix_idx_d;
            num_q       <= num_d;
            drain_q     <= drain_d;
            mac_clr_q   <= mac_clr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The ROM read is combinational, so the MAC enable follows the activation stream directly.
    assign bus.act_ready = (state_q == S_RUN);
    assign bus.mac_en    = (state_q == S_RUN) && bus.act_valid;
    assign bus.mac_last  = (state_q == S_RUN) && bus.act_valid && (rom_addr_q == LAST_TAP);
    assign bus.rom_addr  = rom_addr_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pix_idx   = pix_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_expand3_weight_sched.sv
// Scoreboard bench for expand3_weight_sched: expected handshakes and done pulses are queued
// when a pass is launched and popped as the sequencer produces them.
module tb_expand3_weight_sched;
    localparam int ADDR      = 7;
    localparam int TAPS      = 128;
    localparam int PIX_W     = 12;
    localparam int LAT       = 2;
    localparam int STALL_LEN = 5;
    localparam int HN        = 2048;
    localparam int BUDGET    = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    expand3_weight_sched_if #(.ADDR(ADDR), .PIX_W(PIX_W)) bus  ();
    expand3_weight_sched_if #(.ADDR(ADDR), .PIX_W(PIX_W)) bus0 ();

    expand3_weight_sched #(.ADDR(ADDR), .TAPS(TAPS), .PIX_W(PIX_W), .MAC_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Zero-latency build shares the stimulus and never sees back-pressure.
    expand3_weight_sched #(.ADDR(ADDR), .TAPS(TAPS), .PIX_W(PIX_W), .MAC_LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    assign bus0.start      = bus.start;
    assign bus0.num_pixels = bus.num_pixels;
    assign bus0.abort      = bus.abort;
    assign bus0.act_valid  = bus.act_valid;
    assign bus0.out_ready  = 1'b1;

    typedef struct {
        int pix;
        int cyc;
    } hs_t;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  t0    = 1 << 30;
    int  rel   = -(1 << 30);
    int  stall_at = -1, bp_len = 0, again_at = -1, abort_at = -1, go_num = 0, bp_cnt = 0;
    bit  go_req = 1'b0;
    hs_t hs_q[$];
    int  done_q[$];
    int  n_en, n_clr, n_last, n_done, n_hs, addr_err, excl_err, ov_drop;
    int  first_clr, first_ov, last_cyc, l0_ov, l0_last, exp_addr;
    bit  ov_pend;
    logic             busy_h [HN];
    logic [ADDR-1:0]  addr_h [HN];
    logic [PIX_W-1:0] pix_h  [HN];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, observe at the falling edge.
    task automatic step();
        hs_t e;
        @(posedge clk);
        #2;
        cyc++;
        if (go_req) begin
            go_req = 1'b0;
            t0     = cyc;
        end
        rel = cyc - t0;
        bus.start      = (rel == 0) || (rel == again_at);
        bus.num_pixels = (rel == 0) ? PIX_W'(go_num) : PIX_W'(5);
        bus.abort      = (rel == abort_at);
        bus.act_valid  = !(stall_at >= 0 && rel >= stall_at && rel < stall_at + STALL_LEN);
        if (bus.out_valid) begin
            bus.out_ready = (bp_cnt >= bp_len);
            bp_cnt++;
        end else begin
            bus.out_ready = 1'b0;
            bp_cnt        = 0;
        end

        @(negedge clk);
        if (!rst) begin
            if (rel >= 0 && rel < HN) begin
                busy_h[rel] = bus.busy;
                addr_h[rel] = bus.rom_addr;
                pix_h[rel]  = bus.pix_idx;
            end
            if (bus.mac_clr) begin
                n_clr++;
                if (first_clr < 0) first_clr = rel;
                exp_addr = 0;
            end
            if (bus.mac_en) begin
                n_en++;
                if (bus.rom_addr !== ADDR'(exp_addr)) addr_err++;
                exp_addr++;
            end
            if (bus.mac_last) begin
                n_last++;
                last_cyc = rel;
                if (!bus.mac_en || bus.rom_addr !== ADDR'(TAPS - 1)) addr_err++;
            end
            if ((int'(bus.mac_clr) + int'(bus.mac_en) + int'(bus.out_valid)) > 1) excl_err++;
            if (ov_pend && !bus.out_valid) ov_drop++;
            if (bus.out_valid && first_ov < 0) first_ov = rel;
            if (bus.out_valid && bus.out_ready) begin
                n_hs++;
                $display("hs pix=%0d cyc=%0d", bus.pix_idx, rel);
                if (hs_q.size() == 0) begin
                    chk("hs_unexpected", 1, 0);
                end else begin
                    e = hs_q.pop_front();
                    chk("hs_pix", bus.pix_idx, e.pix);
                    chk("hs_cyc", rel, e.cyc);
                end
                ov_pend = 1'b0;
            end else begin
                ov_pend = bus.out_valid;
            end
            if (bus.done) begin
                n_done++;
                $display("done cyc=%0d", rel);
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else                    chk("done_cyc", rel, done_q.pop_front());
            end
            if (bus0.out_valid && l0_ov < 0) l0_ov = rel;
            if (bus0.mac_last) l0_last = rel;
        end
    endtask

    task automatic run_pass(input string name, input int npix, input int stall_i,
                            input int bp_i, input int again_i, input int abort_i);
        int  c, ov, steps;
        hs_t e;
        hs_q.delete();
        done_q.delete();
        n_en = 0; n_clr = 0; n_last = 0; n_done = 0; n_hs = 0;
        addr_err = 0; excl_err = 0; ov_drop = 0; exp_addr = 0; ov_pend = 1'b0;
        first_clr = -1; first_ov = -1; last_cyc = -1; l0_ov = -1; l0_last = -1;

        // Expected timeline: CLEAR, TAPS run cycles (+stall), LAT drain, OUT (+back-pressure).
        c = 1;
        if (npix == 0) done_q.push_back(1);
        for (int p = 0; p < npix; p++) begin
            ov    = c + 1 + TAPS + LAT + ((p == 0 && stall_i >= 0) ? STALL_LEN : 0);
            e.pix = p;
            e.cyc = ov + bp_i;
            hs_q.push_back(e);
            c = e.cyc + 1;
            if (abort_i >= 0) break;
            if (p == npix - 1) done_q.push_back(c);
        end

        stall_at = stall_i; bp_len = bp_i; again_at = again_i; abort_at = abort_i;
        go_num   = npix;
        go_req   = 1'b1;

        steps = 0;
        while (steps < BUDGET) begin
            step();
            steps++;
            if (abort_i >= 0 && rel >= abort_i + 8) break;
            if (abort_i < 0 && n_done > 0) begin
                step();
                step();
                break;
            end
        end

        chk({name, "_timeout"}, (steps >= BUDGET) ? 1 : 0, 0);
        chk({name, "_n_hs"},   n_hs,   (abort_i >= 0) ? 1 : npix);
        chk({name, "_n_done"}, n_done, (abort_i >= 0) ? 0 : 1);
        chk({name, "_n_clr"},  n_clr,  (abort_i >= 0) ? 2 : npix);
        chk({name, "_n_en"},   n_en,   (abort_i >= 0) ? TAPS + 78 : TAPS * npix);
        chk({name, "_n_last"}, n_last, (abort_i >= 0) ? 1 : npix);
        chk({name, "_addr_seq"}, addr_err, 0);
        chk({name, "_exclusive"}, excl_err, 0);
        chk({name, "_ov_drop"}, ov_drop, 0);
        chk({name, "_hs_left"}, hs_q.size(), 0);
        chk({name, "_done_left"}, done_q.size(), 0);
        chk({name, "_busy_end"}, bus.busy, 0);

        stall_at = -1; bp_len = 0; again_at = -1; abort_at = -1;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.num_pixels = '0;
        bus.abort      = 1'b0;
        bus.act_valid  = 1'b0;
        bus.out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_pix_idx", bus.pix_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mac_clr", bus.mac_clr, 0);
        chk("rst_act_ready", bus.act_ready, 0);
        rst = 1'b0;
        step();
        step();

        run_pass("single", 1, -1, 0, -1, -1);
        chk("single_clr_cyc", first_clr, 1);
        chk("single_last_cyc", last_cyc, 129);
        chk("single_ov_cyc", first_ov, 132);
        chk("single_busy133", busy_h[133], 1);
        chk("single_busy134", busy_h[134], 0);
        chk("lat0_last_cyc", l0_last, 129);
        chk("lat0_ov_cyc", l0_ov, 130);

        run_pass("stall", 1, 42, 0, -1, -1);
        chk("stall_addr44", addr_h[44], 40);
        chk("stall_addr47", addr_h[47], 40);
        chk("stall_addr48", addr_h[48], 41);
        chk("stall_ov_cyc", first_ov, 137);

        run_pass("bp", 3, -1, 10, -1, -1);

        run_pass("zero", 0, -1, 0, -1, -1);

        run_pass("again", 1, -1, 0, 60, -1);
        chk("again_addr61", addr_h[61], 59);
        chk("again_pix61", pix_h[61], 0);

        run_pass("abort", 2, -1, 0, -1, 211);
        chk("abort_addr211", addr_h[211], 77);
        chk("abort_pix211", pix_h[211], 1);
        chk("abort_busy212", busy_h[212], 0);
        chk("abort_addr212", addr_h[212], 0);
        chk("abort_pix212", pix_h[212], 0);

        // Asynchronous reset while the pixel is draining.
        hs_q.delete();
        done_q.delete();
        go_num = 1;
        go_req = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rel == 130) break;
        end
        chk("rstd_rel", rel, 130);
        chk("rstd_busy_before", bus.busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstd_rom_addr", bus.rom_addr, 0);
        chk("rstd_pix_idx", bus.pix_idx, 0);
        chk("rstd_busy", bus.busy, 0);
        chk("rstd_out_valid", bus.out_valid, 0);
        chk("rstd_mac_clr", bus.mac_clr, 0);
        chk("rstd_mac_en", bus.mac_en, 0);
        chk("rstd_done", bus.done, 0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("rstd_idle_wait", bus.busy, 0);

        run_pass("clean", 2, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
